// File: rtl/cache_pkg.sv
// Shared definitions for the L1 data cache controller.
//   SETS, INDEX_W, TAG_W : cache geometry (64 sets, 6-bit index, 10-bit tag)
//   LINE_W, WORD_W       : line is two 32-bit words
//   state_t              : controller FSM state encoding
package cache_pkg;
   localparam int SETS    = 64;
   localparam int INDEX_W = 6;
   localparam int TAG_W   = 10;
   localparam int WORD_W  = 32;
   localparam int LINE_W  = 2 * WORD_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } state_t;
endpackage

// File: rtl/cache_way_mem.sv
// One way of the cache: tag, valid bit and 64-bit line per set.
// Reads are combinational, writes are synchronous.
//   clk, rst      : clock, async active-high reset (clears valid bits only)
//   line_we       : write tag + full line and set valid (miss fill)
//   word_we       : write one word of the line selected by word_sel (write hit)
//   index         : set index for both read and write
//   wr_tag        : tag written on line_we
//   wr_line       : line written on line_we ([31:0]=word0, [63:32]=word1)
//   wr_word       : word written on word_we
//   rd_tag/rd_valid/rd_line : contents of the indexed set
module cache_way_mem
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               line_we,
   input  logic               word_we,
   input  logic               word_sel,
   input  logic [INDEX_W-1:0] index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [LINE_W-1:0]  wr_line,
   input  logic [WORD_W-1:0]  wr_word,
   output logic [TAG_W-1:0]   rd_tag,
   output logic               rd_valid,
   output logic [LINE_W-1:0]  rd_line
);
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [LINE_W-1:0] data_mem [SETS];
   logic [SETS-1:0]   valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (line_we) begin
         valid_q[index] <= 1'b1;
      end
   end

   // Tag and data need no reset: valid gates every use of them.
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_mem[index]  <= wr_tag;
         data_mem[index] <= wr_line;
      end else if (word_we) begin
         if (word_sel) begin
            data_mem[index][LINE_W-1:WORD_W] <= wr_word;
         end else begin
            data_mem[index][WORD_W-1:0] <= wr_word;
         end
      end
   end

   assign rd_tag   = tag_mem[index];
   assign rd_valid = valid_q[index];
   assign rd_line  = data_mem[index];
endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache
// controller sitting between the memory stage and an SRAM controller.
//   clk, rst             : clock, async active-high reset
//   rd_en, wr_en         : memory-stage requests, held until ready=1 (write wins)
//   addr, wdata          : byte address and store data
//   rdata, ready         : load data and completion; ready=0 stalls the pipeline
//   sram_rd_en/sram_wr_en: line read / word write requests to the SRAM controller
//   sram_addr, sram_wdata: SRAM halfword address and write word
//   sram_rdata           : returned line (halfword-swapped word layout)
//   sram_ready           : SRAM transaction done
//   state_dbg            : current FSM state
// Handshake: a request is held stable from the cycle it is raised until the
// cycle ready=1; it completes at the clock edge ending that cycle, and a new
// request may be presented in the following cycle. The SRAM side behaves the
// same way with sram_rd_en/sram_wr_en as valid and sram_ready as ready.
module cache_controller
   import cache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        sram_rd_en,
   output logic        sram_wr_en,
   output logic [17:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [63:0] sram_rdata,
   input  logic        sram_ready,
   output state_t      state_dbg
);
   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic               word_sel;
   logic               unused_addr_bits;

   assign word_sel = addr[2];
   assign index    = addr[8:3];
   assign tag      = addr[18:9];
   assign unused_addr_bits = ^{addr[31:19], addr[1:0]};

   state_t          state_q, state_d;
   logic [SETS-1:0] lru_q;     // per set: the way to replace next
   logic            lru_we, lru_val;
   logic            fill_en, word_wr_en;

   logic [TAG_W-1:0]  tag0, tag1;
   logic              valid0, valid1;
   logic [LINE_W-1:0] line0, line1;
   logic              hit0, hit1, hit, hit_way;
   logic [LINE_W-1:0] hit_line;
   logic [WORD_W-1:0] hit_word, fill_w0, fill_w1;
   logic              fill_way;

   // Way 0 wins if both ways match (only possible from a corrupted state).
   assign hit0     = valid0 && (tag0 == tag);
   assign hit1     = valid1 && (tag1 == tag);
   assign hit      = hit0 || hit1;
   assign hit_way  = !hit0;
   assign hit_line = hit0 ? line0 : line1;
   assign hit_word = word_sel ? hit_line[LINE_W-1:WORD_W] : hit_line[WORD_W-1:0];

   // The SRAM controller returns each word with its halfwords swapped.
   assign fill_w0  = {sram_rdata[47:32], sram_rdata[63:48]};
   assign fill_w1  = {sram_rdata[15:0],  sram_rdata[31:16]};
   assign fill_way = lru_q[index];

   cache_way_mem u_way0 (
      .clk      (clk),
      .rst      (rst),
      .line_we  (fill_en && !fill_way),
      .word_we  (word_wr_en && hit0),
      .word_sel (word_sel),
      .index    (index),
      .wr_tag   (tag),
      .wr_line  ({fill_w1, fill_w0}),
      .wr_word  (wdata),
      .rd_tag   (tag0),
      .rd_valid (valid0),
      .rd_line  (line0)
   );

   cache_way_mem u_way1 (
      .clk      (clk),
      .rst      (rst),
      .line_we  (fill_en && fill_way),
      .word_we  (word_wr_en && hit1 && !hit0),
      .word_sel (word_sel),
      .index    (index),
      .wr_tag   (tag),
      .wr_line  ({fill_w1, fill_w0}),
      .wr_word  (wdata),
      .rd_tag   (tag1),
      .rd_valid (valid1),
      .rd_line  (line1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lru_q   <= '0;
      end else begin
         state_q <= state_d;
         if (lru_we) begin
            lru_q[index] <= lru_val;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ready      = 1'b0;
      rdata      = hit_word;
      sram_rd_en = 1'b0;
      sram_wr_en = 1'b0;
      sram_addr  = addr[18:1];
      fill_en    = 1'b0;
      word_wr_en = 1'b0;
      lru_we     = 1'b0;
      lru_val    = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_en) begin
               state_d = WR_THRU;
            end else if (rd_en) begin
               if (hit) begin
                  ready   = 1'b1;
                  lru_we  = 1'b1;
                  lru_val = !hit_way;
               end else begin
                  state_d = RD_MISS;
               end
            end else begin
               ready = 1'b1;
            end
         end
         RD_MISS: begin
            sram_rd_en = 1'b1;
            sram_addr  = {addr[18:3], 2'b00};
            if (sram_ready) begin
               ready   = 1'b1;
               rdata   = word_sel ? fill_w1 : fill_w0;
               fill_en = 1'b1;
               lru_we  = 1'b1;
               lru_val = !fill_way;
               state_d = IDLE;
            end
         end
         WR_THRU: begin
            sram_wr_en = 1'b1;
            sram_addr  = addr[18:1];
            if (sram_ready) begin
               ready   = 1'b1;
               state_d = IDLE;
               // Write-through: update only a resident line, never allocate.
               if (hit) begin
                  word_wr_en = 1'b1;
                  lru_we     = 1'b1;
                  lru_val    = !lru_q[index];
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sram_wdata = wdata;
   assign state_dbg  = state_q;
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a behavioural SRAM with fixed
// six-cycle latency, a cache-contents model (tags/valid/LRU per set) and
// directed plus randomized request sequences.
module tb_cache_controller;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready;
   logic        sram_rd_en;
   logic        sram_wr_en;
   logic [17:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [63:0] sram_rdata;
   logic        sram_ready;
   state_t      state_dbg;

   int errors = 0;
   int checks = 0;

   cache_controller dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .ready      (ready),
      .sram_rd_en (sram_rd_en),
      .sram_wr_en (sram_wr_en),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_ready (sram_ready),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   // ---------------- SRAM model: word memory, done in 6th request cycle ----
   logic [31:0] smem [0:131071];
   int          sram_cnt;
   logic [16:0] wa0;
   logic [31:0] w0, w1;

   assign sram_ready = (sram_rd_en || sram_wr_en) && (sram_cnt == 5);

   always_comb begin
      wa0 = {sram_addr[17:2], 1'b0};
      w0  = smem[wa0];
      w1  = smem[wa0 + 17'd1];
      sram_rdata = {w0[15:0], w0[31:16], w1[15:0], w1[31:16]};
   end

   always @(posedge clk or posedge rst) begin
      if (rst) sram_cnt <= 0;
      else if (sram_ready || !(sram_rd_en || sram_wr_en)) sram_cnt <= 0;
      else sram_cnt <= sram_cnt + 1;
   end

   always @(posedge clk) begin
      if (sram_wr_en && sram_ready) smem[sram_addr[17:1]] <= sram_wdata;
   end

   // ---------------- cache reference model ---------------------------------
   bit          m_valid [2][64];
   logic [9:0]  m_tag   [2][64];
   bit          m_lru   [64];   // way to replace next

   task automatic model_reset();
      for (int s = 0; s < 64; s++) begin
         m_valid[0][s] = 0;
         m_valid[1][s] = 0;
         m_lru[s]      = 0;
      end
   endtask

   // Drive one request starting at a negedge; returns at a negedge with the
   // request dropped. exp_lat=0 means take the latency from the model.
   task automatic do_access(input bit is_wr, input logic [31:0] a,
                            input logic [31:0] wd, input int exp_lat,
                            output logic [31:0] got);
      logic [5:0]  idx;
      logic [9:0]  tg;
      logic [31:0] exp_data;
      logic [17:0] exp_sa;
      bit          hit, hw, done, w;
      int          lat, cyc;
      idx = a[8:3];
      tg  = a[18:9];
      hit = 0;
      hw  = 0;
      if (m_valid[0][idx] && m_tag[0][idx] == tg) begin hit = 1; hw = 0; end
      else if (m_valid[1][idx] && m_tag[1][idx] == tg) begin hit = 1; hw = 1; end
      lat      = (exp_lat != 0) ? exp_lat : ((is_wr || !hit) ? 7 : 1);
      exp_data = smem[a[18:2]];
      exp_sa   = is_wr ? a[18:1] : {a[18:3], 2'b00};
      got      = 'x;
      rd_en = !is_wr;
      wr_en = is_wr;
      addr  = a;
      wdata = wd;
      cyc   = 1;
      done  = 0;
      while (!done && cyc <= 40) begin
         #1;
         checks++;
         if (cyc == 1) begin
            if ({sram_rd_en, sram_wr_en} !== 2'b00) begin
               errors++;
               $display("FAIL idle_sram_en a=%h got=%b want=00", a, {sram_rd_en, sram_wr_en});
            end
         end else begin
            if ({sram_rd_en, sram_wr_en, sram_addr} !== {!is_wr, is_wr, exp_sa} ||
                (is_wr && sram_wdata !== wd)) begin
               errors++;
               $display("FAIL sram_req a=%h cyc=%0d got rd=%b wr=%b sa=%h wd=%h want rd=%b wr=%b sa=%h wd=%h",
                        a, cyc, sram_rd_en, sram_wr_en, sram_addr, sram_wdata, !is_wr, is_wr, exp_sa, wd);
            end
         end
         if (ready) begin
            done = 1;
            got  = rdata;
            checks++;
            if (cyc != lat) begin
               errors++;
               $display("FAIL latency a=%h wr=%b got=%0d want=%0d", a, is_wr, cyc, lat);
            end
            if (!is_wr) begin
               checks++;
               if (rdata !== exp_data) begin
                  errors++;
                  $display("FAIL rdata a=%h got=%h want=%h", a, rdata, exp_data);
               end
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         errors++;
         $display("FAIL timeout a=%h wr=%b got=no_ready want=ready", a, is_wr);
      end
      rd_en = 0;
      wr_en = 0;
      // update model with the completed transaction
      if (done) begin
         if (is_wr) begin
            if (hit) m_lru[idx] = !m_lru[idx];
         end else if (hit) begin
            m_lru[idx] = !hw;
         end else begin
            w = m_lru[idx];
            m_valid[w][idx] = 1;
            m_tag[w][idx]   = tg;
            m_lru[idx]      = !w;
         end
      end
   endtask

   // ---------------- tests --------------------------------------------------
   task automatic test_reset();
      rst = 1;
      @(negedge clk);
      #1;
      checks++;
      if ({ready, sram_rd_en, sram_wr_en} !== 3'b100 || state_dbg !== IDLE) begin
         errors++;
         $display("FAIL reset_outputs got rdy/rd/wr=%b st=%0d want=100 st=0",
                  {ready, sram_rd_en, sram_wr_en}, state_dbg);
      end
      @(negedge clk);
      rst = 0;
      model_reset();
      #1;
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_ready got=%b want=1", ready);
      end
      @(negedge clk);
   endtask

   task automatic test_read_miss();
      logic [31:0] g;
      do_access(0, 32'h0000_0408, '0, 7, g);
   endtask

   task automatic test_read_hits();
      logic [31:0] g;
      do_access(0, 32'h0000_0408, '0, 1, g);
      do_access(0, 32'h0000_040C, '0, 1, g);
   endtask

   task automatic test_eviction();
      logic [31:0] g;
      do_access(0, 32'h0000_8408, '0, 7, g);
      do_access(0, 32'h0001_0408, '0, 7, g);
      do_access(0, 32'h0000_0408, '0, 7, g);
   endtask

   task automatic test_write_hit();
      logic [31:0] g;
      do_access(1, 32'h0000_040C, 32'hDEAD_BEEF, 7, g);
      do_access(0, 32'h0000_040C, '0, 1, g);
      checks++;
      if (g !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_hit_data got=%h want=deadbeef", g);
      end
   endtask

   task automatic test_write_no_alloc();
      logic [31:0] g;
      do_access(1, 32'h0000_2000, 32'h1234_5678, 7, g);
      do_access(0, 32'h0000_2000, '0, 7, g);
      checks++;
      if (g !== 32'h1234_5678) begin
         errors++;
         $display("FAIL no_alloc_data got=%h want=12345678", g);
      end
   endtask

   task automatic test_reset_mid_miss();
      logic [31:0] g;
      rd_en = 1;
      addr  = 32'h0000_3008;
      repeat (3) @(negedge clk);
      #2;
      rst = 1;
      #1;
      checks++;
      if (sram_rd_en !== 1'b0 || state_dbg !== IDLE) begin
         errors++;
         $display("FAIL reset_mid_miss got rd=%b st=%0d want rd=0 st=0", sram_rd_en, state_dbg);
      end
      rd_en = 0;
      #1;
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got=%b want=1", ready);
      end
      @(negedge clk);
      rst = 0;
      model_reset();
      do_access(0, 32'h0000_3008, '0, 7, g);
   endtask

   task automatic test_random();
      logic [31:0] a, g;
      bit          is_wr;
      for (int n = 0; n < 150; n++) begin
         a       = $urandom;
         a[18:9] = 10'($urandom_range(0, 3));
         a[8:3]  = 6'($urandom_range(0, 3));
         is_wr   = ($urandom_range(0, 9) < 4);
         do_access(is_wr, a, $urandom, 0, g);
         if ($urandom_range(0, 3) == 0) begin
            #1;
            checks++;
            if (ready !== 1'b1) begin
               errors++;
               $display("FAIL gap_ready got=%b want=1", ready);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 131072; i++) smem[i] = $urandom;
      test_reset();
      test_read_miss();
      test_read_hits();
      test_eviction();
      test_write_hit();
      test_write_no_alloc();
      test_reset_mid_miss();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
